// File: rtl/music_sequencer_pkg.sv
// Shared definitions for the music sequencer: note-word layout, beat codes,
// quarter-beat lookup values and the sequencer state encoding.
package music_sequencer_pkg;

  localparam int NOTE_W  = 10;
  localparam int CODE_W  = 6;
  localparam int QBEAT_W = 5;

  // Shifter head word: [9]=ligature, [8:6]=beat code, [5:0]=note code.
  typedef struct packed {
    logic              lig;
    logic [2:0]        beat;
    logic [CODE_W-1:0] code;
  } note_word_t;

  localparam logic [CODE_W-1:0] ENCODE_NA = '0;

  localparam logic [2:0] BEAT_1Q  = 3'd0;
  localparam logic [2:0] BEAT_2Q  = 3'd1;
  localparam logic [2:0] BEAT_4Q  = 3'd2;
  localparam logic [2:0] BEAT_8Q  = 3'd3;
  localparam logic [2:0] BEAT_12Q = 3'd4;
  localparam logic [2:0] BEAT_16Q = 3'd5;

  localparam logic [QBEAT_W-1:0] QB_1   = 5'd1;
  localparam logic [QBEAT_W-1:0] QB_2   = 5'd2;
  localparam logic [QBEAT_W-1:0] QB_4   = 5'd4;
  localparam logic [QBEAT_W-1:0] QB_8   = 5'd8;
  localparam logic [QBEAT_W-1:0] QB_12  = 5'd12;
  localparam logic [QBEAT_W-1:0] QB_16  = 5'd16;
  localparam logic [QBEAT_W-1:0] QB_DEF = 5'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_ADV,
    ST_REWIND
  } seq_state_t;

endpackage

// File: rtl/music_beat_decode.sv
// Beat code to note length in quarter-beats; the two reserved codes fall
// back to a plain quarter note (4 quarter-beats).
module music_beat_decode
  import music_sequencer_pkg::*;
(
  input  logic [2:0]         i_beat,
  output logic [QBEAT_W-1:0] o_qbeats
);

  always_comb begin
    case (i_beat)
      BEAT_1Q:  o_qbeats = QB_1;
      BEAT_2Q:  o_qbeats = QB_2;
      BEAT_4Q:  o_qbeats = QB_4;
      BEAT_8Q:  o_qbeats = QB_8;
      BEAT_12Q: o_qbeats = QB_12;
      BEAT_16Q: o_qbeats = QB_16;
      default:  o_qbeats = QB_DEF;
    endcase
  end

endmodule

// File: rtl/music_sequencer.sv
// Tempo/sequencing controller: times each note word from the song shifter,
// gates the tone generator and pulses the shifter to advance or rewind.
module music_sequencer
  import music_sequencer_pkg::*;
#(
  parameter int TICKS_PER_QBEAT = 8192,
  parameter int GAP_TICKS       = 1024,
  parameter int SONG_LEN        = 133,
  parameter int IDX_W           = 8,
  parameter int CNT_W           = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_pause,
  input  logic              i_loop_en,
  input  logic [NOTE_W-1:0] i_note_word,
  output logic              o_note_adv,
  output logic              o_tone_en,
  output logic [CODE_W-1:0] o_note_code,
  output logic [IDX_W-1:0]  o_note_idx,
  output logic              o_busy,
  output logic              o_done
);

  seq_state_t         r_state;
  seq_state_t         w_next_state;
  logic [CNT_W-1:0]   r_rem;
  logic [IDX_W-1:0]   r_idx;
  logic [CODE_W-1:0]  r_code;
  logic               r_lig;
  logic               r_tone_en;
  logic               r_done;

  note_word_t         w_word;
  logic [QBEAT_W-1:0] w_qbeats;
  logic [CNT_W-1:0]   w_dur;
  logic [IDX_W-1:0]   w_idx_inc;
  logic               w_last;
  logic               w_sounding;
  logic               w_tone_next;

  assign w_word = note_word_t'(i_note_word);

  music_beat_decode u_beat_decode (
    .i_beat   (w_word.beat),
    .o_qbeats (w_qbeats)
  );

  assign w_dur      = CNT_W'(w_qbeats) * CNT_W'(TICKS_PER_QBEAT);
  assign w_last     = (r_idx == IDX_W'(SONG_LEN - 1));
  assign w_idx_inc  = w_last ? '0 : r_idx + IDX_W'(1);
  // rem counts the cycles left in the note period including the current one.
  assign w_sounding = (r_code != ENCODE_NA) && (r_lig || (r_rem > CNT_W'(GAP_TICKS)));

  // NOTE: async reset lives only in the sensitivity list and the first branch;
  // state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: every always_comb assigns a default first so no path infers a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (i_start && !i_stop) w_next_state = ST_LOAD;
      ST_LOAD:   if (i_stop)             w_next_state = ST_REWIND;
                 else if (!i_pause)      w_next_state = ST_PLAY;
      ST_PLAY:   if (i_stop)             w_next_state = ST_REWIND;
                 else if (!i_pause && r_rem == CNT_W'(2)) w_next_state = ST_ADV;
      ST_ADV:    if (i_stop)             w_next_state = ST_REWIND;
                 else if (w_last && !i_loop_en) w_next_state = ST_IDLE;
                 else                    w_next_state = ST_LOAD;
      ST_REWIND: if (r_idx == '0)        w_next_state = ST_IDLE;
      default:                           w_next_state = ST_IDLE;
    endcase
  end

  // Tone is computed one cycle ahead; in LOAD it looks at the incoming word.
  always_comb begin
    o_note_adv  = 1'b0;
    w_tone_next = 1'b0;
    o_busy      = (r_state != ST_IDLE);
    case (r_state)
      ST_LOAD:   w_tone_next = (w_word.code != ENCODE_NA) &&
                               (w_word.lig || (w_dur > CNT_W'(GAP_TICKS)));
      ST_PLAY:   w_tone_next = w_sounding;
      ST_ADV: begin
        o_note_adv  = 1'b1;
        w_tone_next = w_sounding;
      end
      ST_REWIND: o_note_adv = (r_idx != '0);
      default:   ;
    endcase
    w_tone_next = w_tone_next && !i_pause &&
                  (w_next_state inside {ST_LOAD, ST_PLAY, ST_ADV});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem     <= '0;
      r_idx     <= '0;
      r_code    <= ENCODE_NA;
      r_lig     <= 1'b0;
      r_tone_en <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_tone_en <= w_tone_next;
      r_done    <= (r_state == ST_ADV) && (w_next_state == ST_IDLE);
      case (r_state)
        ST_LOAD: if (w_next_state == ST_PLAY) begin
          r_code <= w_word.code;
          r_lig  <= w_word.lig;
          r_rem  <= w_dur - CNT_W'(1);
        end
        ST_PLAY:   if (!i_pause && !i_stop) r_rem <= r_rem - CNT_W'(1);
        ST_ADV:    r_idx <= w_idx_inc;
        ST_REWIND: if (r_idx != '0) r_idx <= w_idx_inc;
        default:   ;
      endcase
    end
  end

  assign o_tone_en   = r_tone_en;
  assign o_done      = r_done;
  assign o_note_code = r_code;
  assign o_note_idx  = r_idx;

endmodule

// File: tb/tb_music_sequencer.sv
// Bench for music_sequencer: a 4-entry rotating shifter, a note-period model
// compared every cycle, directed scenarios with literal expectations, then random traffic.
module tb_music_sequencer;

  localparam int TPQ   = 4;
  localparam int GAP   = 2;
  localparam int LEN   = 4;
  localparam int IDX_W = 2;
  localparam int CNT_W = 8;

  localparam int M_IDLE = 0;
  localparam int M_NOTE = 1;
  localparam int M_REW  = 2;

  logic clk = 1'b0;
  logic rst_n, start, stop, pause, loop_en;
  logic [9:0] note_word;
  logic note_adv, tone_en, busy, done;
  logic [5:0] note_code;
  logic [IDX_W-1:0] note_idx;

  logic [9:0] song [LEN];
  logic [1:0] sh_head;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: position within the current note period, counted in unpaused cycles.
  int m_mode, m_pos, m_D, m_idx, m_code, m_lig, m_tone, m_done;
  int qb_tab [8] = '{1, 2, 4, 8, 12, 16, 4, 4};

  always #5 clk = ~clk;

  music_sequencer #(
    .TICKS_PER_QBEAT (TPQ),
    .GAP_TICKS       (GAP),
    .SONG_LEN        (LEN),
    .IDX_W           (IDX_W),
    .CNT_W           (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (start),
    .i_stop      (stop),
    .i_pause     (pause),
    .i_loop_en   (loop_en),
    .i_note_word (note_word),
    .o_note_adv  (note_adv),
    .o_tone_en   (tone_en),
    .o_note_code (note_code),
    .o_note_idx  (note_idx),
    .o_busy      (busy),
    .o_done      (done)
  );

  // Rotating song shifter sharing the sequencer reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)        sh_head <= 2'd0;
    else if (note_adv) sh_head <= sh_head + 2'd1;
  end
  assign note_word = song[sh_head];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit sounds();
    return (m_code != 0) && ((m_lig != 0) || (m_D - m_pos) > GAP);
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_pos = 0; m_D = 0; m_idx = 0;
    m_code = 0; m_lig = 0; m_tone = 0; m_done = 0;
  endtask

  task automatic model_step();
    logic [9:0] w;
    bit nt, nd, keep_going;
    nt = 0; nd = 0;
    w = song[m_idx];
    case (m_mode)
      M_IDLE: if (start && !stop) begin m_mode = M_NOTE; m_pos = 0; end
      M_NOTE: begin
        if (m_pos > 0 && m_pos == m_D - 1) begin
          keep_going = !(m_idx == LEN - 1 && !loop_en);
          m_idx = (m_idx + 1) % LEN;
          if (stop)             m_mode = M_REW;
          else if (!keep_going) begin m_mode = M_IDLE; nd = 1; end
          else begin nt = !pause && sounds(); m_pos = 0; end
        end else if (stop) begin
          m_mode = M_REW;
        end else if (!pause) begin
          if (m_pos == 0) begin
            m_code = int'(w[5:0]); m_lig = int'(w[9]); m_D = qb_tab[w[8:6]] * TPQ;
          end
          nt = sounds();
          m_pos++;
        end
      end
      default: if (m_idx != 0) m_idx = (m_idx + 1) % LEN; else m_mode = M_IDLE;
    endcase
    m_tone = nt; m_done = nd;
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) model_reset();
    else begin
      check("busy",      busy,      m_mode != M_IDLE);
      check("note_adv",  note_adv,  (m_mode == M_NOTE && m_pos > 0 && m_pos == m_D - 1) ||
                                    (m_mode == M_REW && m_idx != 0));
      check("tone_en",   tone_en,   m_tone);
      check("note_code", note_code, m_code);
      check("note_idx",  note_idx,  m_idx);
      check("done",      done,      m_done);
      check("shifter_head", sh_head, m_idx);
      model_step();
    end
  end

  // Called just after the edge that enters LOAD; returns just after the edge ending ADV.
  task automatic probe(input int p_from, input int p_len,
                       output int adv_at, output int tone_cnt, output int tail, output int paused_tone);
    adv_at = -1; tone_cnt = 0; tail = 0; paused_tone = 0;
    for (int k = 0; k < 200; k++) begin
      pause = (k >= p_from && k < p_from + p_len);
      @(negedge clk);
      if (k == 0) tail = int'(tone_en);
      else        tone_cnt += int'(tone_en);
      if (k > p_from && k <= p_from + p_len) paused_tone += int'(tone_en);
      if (note_adv) begin adv_at = k; break; end
      @(posedge clk); #1;
    end
    if (adv_at >= 0) begin @(posedge clk); #1; end
    pause = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic randomize_song();
    for (int i = 0; i < LEN; i++) begin
      song[i][9]   = 1'($urandom_range(0, 1));
      song[i][8:6] = 3'($urandom_range(0, 7));
      song[i][5:0] = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
    end
  endtask

  task automatic wait_idle(input string name);
    bit seen = 0;
    for (int j = 0; j < 40 && !seen; j++) begin
      @(negedge clk);
      seen = !busy;
    end
    check(name, seen, 1);
    @(posedge clk); #1;
  endtask

  int a0, a1, a2, a3, t0, t1, t2, t3, l0, l1, l2, l3, pz, adv_n;
  int idx_seq [6];
  int busy_seq [6];
  int pause_burst = 0;

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
    song[0] = {1'b0, 3'd2, 6'd5};
    song[1] = {1'b1, 3'd1, 6'd7};
    song[2] = {1'b0, 3'd0, 6'd0};
    song[3] = {1'b0, 3'd6, 6'd9};
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset in the middle of a note.
    start_pulse();
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_tone", tone_en, 0);
    check("rst_adv",  note_adv, 0);
    check("rst_idx",  note_idx, 0);
    check("rst_code", note_code, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // One pass through the song, no loop.
    start_pulse();
    probe(-10, 0, a0, t0, l0, pz);
    check("n0_adv_cycle", a0, 15);
    check("n0_tone_cycles", t0, 14);
    check("n0_code", note_code, 5);
    check("n0_next_idx", note_idx, 1);
    probe(-10, 0, a1, t1, l1, pz);
    check("n1_adv_cycle", a1, 7);
    check("n1_tail_after_n0", l1, 0);
    probe(-10, 0, a2, t2, l2, pz);
    check("n1_tied_tone_cycles", t1 + l2, 8);
    check("n2_adv_cycle", a2, 3);
    check("n2_rest_tone", t2, 0);
    check("n2_code", note_code, 0);
    probe(-10, 0, a3, t3, l3, pz);
    check("n3_adv_cycle", a3, 15);
    check("n3_tone_cycles", t3 + l3, 14);
    check("end_done", done, 1);
    check("end_busy", busy, 0);
    check("end_idx", note_idx, 0);
    check("end_code_held", note_code, 9);
    @(posedge clk); #1;
    check("end_done_once", done, 0);

    // Pause for 5 cycles while rem is 10, then stop on the third note.
    start_pulse();
    probe(6, 5, a0, t0, l0, pz);
    check("pause_adv_cycle", a0, 20);
    check("pause_tone_cycles", t0, 14);
    check("pause_tone_silent", pz, 0);
    probe(-10, 0, a1, t1, l1, pz);
    check("stop_at_idx", note_idx, 2);
    stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    adv_n = 0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      adv_n += int'(note_adv);
      idx_seq[j] = int'(note_idx);
      busy_seq[j] = int'(busy);
    end
    check("rewind_pulses", adv_n, 2);
    check("rewind_idx0", idx_seq[0], 2);
    check("rewind_idx1", idx_seq[1], 3);
    check("rewind_idx2", idx_seq[2], 0);
    check("rewind_busy2", busy_seq[2], 1);
    check("rewind_busy3", busy_seq[3], 0);
    check("rewind_head", sh_head, 0);
    @(posedge clk); #1;

    // Looping playback wraps straight into LOAD with no done.
    loop_en = 1'b1;
    start_pulse();
    for (int n = 0; n < LEN; n++) probe(-10, 0, a0, t0, l0, pz);
    check("loop_no_done", done, 0);
    check("loop_busy", busy, 1);
    check("loop_idx", note_idx, 0);
    check("loop_code_prev", note_code, 9);
    probe(-10, 0, a0, t0, l0, pz);
    check("loop_again_adv", a0, 15);
    stop = 1'b1; loop_en = 1'b0;
    @(posedge clk); #1 stop = 1'b0;
    wait_idle("loop_stop_idle");

    // Random traffic against the model, with one mid-run reset.
    randomize_song();
    for (int c = 0; c < 4000; c++) begin
      start = ($urandom_range(0, 15) == 0);
      stop  = ($urandom_range(0, 79) == 0);
      if (pause_burst == 0 && $urandom_range(0, 24) == 0) pause_burst = $urandom_range(1, 6);
      pause = (pause_burst > 0);
      if (pause_burst > 0) pause_burst--;
      if ($urandom_range(0, 199) == 0) loop_en = ~loop_en;
      if (c == 2000) begin
        rst_n = 1'b0;
        randomize_song();
        @(posedge clk); #1 rst_n = 1'b1;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; pause = 1'b0; loop_en = 1'b0; stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    wait_idle("final_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
